// File: rtl/rfs_timer_scheduler.sv
// Avalon-MM master for the RFS interval timer: programs/starts/stops it, acknowledges
// timeouts, divides them into sample strobes and services 32-bit counter snapshots.
module rfs_timer_scheduler #(
  parameter logic [31:0] PERIOD_MIN = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [31:0] cfg_period,
  input  logic [7:0]  cfg_ticks,
  input  logic        snap_req,
  output logic [2:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic        running,
  output logic        busy,
  output logic        sample_stb,
  output logic [15:0] sample_count,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic        cfg_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_RUN, S_ACK,
    S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_CAP, S_STOP_CTL, S_STOP_ST
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_period;
  logic [7:0]  r_ticks, r_tick_cnt;
  logic        r_stop_pend, r_snap_pend, r_running;
  logic        r_sample_stb, r_snap_valid, r_cfg_err;
  logic [15:0] r_sample_count;
  logic [31:0] r_snap_value;
  logic        w_stop_pend, w_snap_pend, w_start_ok;
  logic [7:0]  w_tick_last;

  // A request arriving this cycle counts as pending, so RUN reacts on the next edge.
  assign w_stop_pend = r_stop_pend | cfg_stop;
  assign w_snap_pend = r_snap_pend | snap_req;
  assign w_start_ok  = (cfg_period >= PERIOD_MIN);
  assign w_tick_last = (r_ticks == 8'd0) ? 8'd0 : r_ticks - 8'd1;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (cfg_start) begin
          if (w_start_ok) w_next = S_WR_PL;
        end else if (w_snap_pend) begin
          w_next = S_SNAP_WR;
        end
      end
      S_WR_PL:    w_next = S_WR_PH;
      S_WR_PH:    w_next = S_WR_CTL;
      S_WR_CTL:   w_next = S_RUN;
      S_RUN: begin
        if (w_stop_pend)      w_next = S_STOP_CTL;
        else if (tmr_irq)     w_next = S_ACK;
        else if (w_snap_pend) w_next = S_SNAP_WR;
      end
      S_ACK:      w_next = S_RUN;
      S_SNAP_WR:  w_next = S_SNAP_RL;
      S_SNAP_RL:  w_next = S_SNAP_RH;
      S_SNAP_RH:  w_next = S_SNAP_CAP;
      S_SNAP_CAP: w_next = r_running ? S_RUN : S_IDLE;
      S_STOP_CTL: w_next = S_STOP_ST;
      S_STOP_ST:  w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    unique case (r_state)
      S_WR_PL:    begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd2; tmr_writedata = r_period[15:0];  end
      S_WR_PH:    begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd3; tmr_writedata = r_period[31:16]; end
      S_WR_CTL:   begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = 16'h0007; end
      S_ACK:      begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd0; end
      S_SNAP_WR:  begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd4; end
      S_SNAP_RL:  begin tmr_chipselect = 1'b1; tmr_address = 3'd4; end
      S_SNAP_RH:  begin tmr_chipselect = 1'b1; tmr_address = 3'd5; end
      S_STOP_CTL: begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd1; tmr_writedata = 16'h0008; end
      S_STOP_ST:  begin tmr_chipselect = 1'b1; tmr_write_n = 1'b0; tmr_address = 3'd0; end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_period       <= 32'd0;
      r_ticks        <= 8'd0;
      r_tick_cnt     <= 8'd0;
      r_stop_pend    <= 1'b0;
      r_snap_pend    <= 1'b0;
      r_running      <= 1'b0;
      r_sample_stb   <= 1'b0;
      r_snap_valid   <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_sample_count <= 16'd0;
      r_snap_value   <= 32'd0;
    end else begin
      r_state      <= w_next;
      r_sample_stb <= 1'b0;
      r_snap_valid <= 1'b0;
      r_cfg_err    <= (r_state == S_IDLE) && cfg_start && !w_start_ok;

      if ((r_state == S_IDLE) && cfg_start && w_start_ok) begin
        r_period <= cfg_period;
        r_ticks  <= cfg_ticks;
      end

      // A stop seen while idle has nothing to stop and is dropped.
      if ((w_next == S_STOP_CTL) || (r_state == S_IDLE)) r_stop_pend <= 1'b0;
      else                                                r_stop_pend <= w_stop_pend;

      if (w_next == S_SNAP_WR) r_snap_pend <= 1'b0;
      else                     r_snap_pend <= w_snap_pend;

      if (r_state == S_WR_CTL) begin
        r_running      <= 1'b1;
        r_tick_cnt     <= 8'd0;
        r_sample_count <= 16'd0;
      end else if (w_next == S_IDLE) begin
        r_running <= 1'b0;
      end

      if (r_state == S_ACK) begin
        if (r_tick_cnt == w_tick_last) begin
          r_tick_cnt     <= 8'd0;
          r_sample_stb   <= 1'b1;
          r_sample_count <= r_sample_count + 16'd1;
        end else begin
          r_tick_cnt <= r_tick_cnt + 8'd1;
        end
      end

      // Read data trails the address by one cycle, hence the RH/CAP capture points.
      if (r_state == S_SNAP_RH) r_snap_value[15:0] <= tmr_readdata;
      if (r_state == S_SNAP_CAP) begin
        r_snap_value[31:16] <= tmr_readdata;
        r_snap_valid        <= 1'b1;
      end
    end
  end

  assign running      = r_running;
  assign busy         = (r_state != S_IDLE) && (r_state != S_RUN);
  assign sample_stb   = r_sample_stb;
  assign sample_count = r_sample_count;
  assign snap_valid   = r_snap_valid;
  assign snap_value   = r_snap_value;
  assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_rfs_timer_scheduler.sv
// Directed bench for rfs_timer_scheduler; a tiny timer read model supplies snapshot data.
module tb_rfs_timer_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_start, cfg_stop, snap_req, tmr_irq;
  logic [31:0] cfg_period;
  logic [7:0]  cfg_ticks;
  logic [2:0]  tmr_address;
  logic        tmr_chipselect, tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata = 16'h0;
  logic        running, busy, sample_stb, snap_valid, cfg_err;
  logic [15:0] sample_count;
  logic [31:0] snap_value;
  logic [15:0] snap_lo, snap_hi;

  int n_checks = 0;
  int n_errors = 0;
  int stb_seen;

  rfs_timer_scheduler #(.PERIOD_MIN(32'd8)) dut (
    .clk(clk), .reset(reset),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .cfg_period(cfg_period), .cfg_ticks(cfg_ticks),
    .snap_req(snap_req),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
    .tmr_writedata(tmr_writedata), .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .running(running), .busy(busy), .sample_stb(sample_stb), .sample_count(sample_count),
    .snap_valid(snap_valid), .snap_value(snap_value), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // Timer read port: one-cycle registered latency, snapshot registers at 4 and 5.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n)
      tmr_readdata <= (tmr_address == 3'd4) ? snap_lo :
                      (tmr_address == 3'd5) ? snap_hi : 16'h0;
    else
      tmr_readdata <= 16'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic wn,
                           input logic [2:0] addr, input logic [15:0] wd);
    check(tag, {11'd0, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata},
               {11'd0, cs, wn, addr, wd});
  endtask

  task automatic check_idle_bus(input string tag);
    check_bus(tag, 1'b0, 1'b1, 3'd0, 16'h0);
  endtask

  // Issue cfg_start and check the three programming writes and entry to RUN.
  task automatic do_start(input string tag, input logic [31:0] period, input logic [7:0] ticks);
    cfg_start = 1'b1; cfg_period = period; cfg_ticks = ticks;
    tick();
    cfg_start = 1'b0;
    check_bus({tag, "_pl"}, 1'b1, 1'b0, 3'd2, period[15:0]);
    check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
    tick();
    check_bus({tag, "_ph"}, 1'b1, 1'b0, 3'd3, period[31:16]);
    tick();
    check_bus({tag, "_ctl"}, 1'b1, 1'b0, 3'd1, 16'h0007);
    check({tag, "_run3"}, {31'd0, running}, 32'd0);
    tick();
    check({tag, "_run4"}, {30'd0, running, busy}, 32'd2);
    check_idle_bus({tag, "_idle4"});
    check({tag, "_cnt0"}, {16'd0, sample_count}, 32'd0);
  endtask

  task automatic do_stop(input string tag);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check_bus({tag, "_ctl"}, 1'b1, 1'b0, 3'd1, 16'h0008);
    tick();
    check_bus({tag, "_st"}, 1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    check({tag, "_idle"}, {30'd0, running, busy}, 32'd0);
    check_idle_bus({tag, "_bus"});
  endtask

  // One irq serviced from RUN: ACK write next cycle, strobe (if due) the cycle after.
  task automatic do_irq(input string tag, input logic exp_stb);
    tmr_irq = 1'b1;
    tick();
    check_bus({tag, "_ack"}, 1'b1, 1'b0, 3'd0, 16'h0000);
    tmr_irq = 1'b0;
    tick();
    check({tag, "_stb"}, {31'd0, sample_stb}, {31'd0, exp_stb});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    if (sample_stb) stb_seen++;
    tick();
    check({tag, "_stb_off"}, {31'd0, sample_stb}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0; tmr_irq = 1'b0;
    cfg_period = 32'd0; cfg_ticks = 8'd0;
    snap_lo = 16'h2345; snap_hi = 16'h0001;
    tick(); tick(); tick();
    reset = 1'b0;

    // Reset state
    check_idle_bus("rst_bus");
    check("rst_flags", {27'd0, running, busy, sample_stb, snap_valid, cfg_err}, 32'd0);
    check("rst_count", {16'd0, sample_count}, 32'd0);
    check("rst_snap", snap_value, 32'd0);

    // Too-small period is rejected with a single cfg_err pulse
    cfg_start = 1'b1; cfg_period = 32'd5; cfg_ticks = 8'd1;
    tick();
    cfg_start = 1'b0;
    check("rej_err", {31'd0, cfg_err}, 32'd1);
    check_idle_bus("rej_bus1");
    check("rej_busy1", {30'd0, running, busy}, 32'd0);
    tick();
    check("rej_err_off", {31'd0, cfg_err}, 32'd0);
    check_idle_bus("rej_bus2");

    // Start period 99, ticks 1; every irq yields a strobe
    stb_seen = 0;
    do_start("s99", 32'd99, 8'd1);
    do_irq("s99_irq1", 1'b1);
    do_irq("s99_irq2", 1'b1);
    check("s99_count", {16'd0, sample_count}, 32'd2);

    // cfg_start while running is ignored
    cfg_start = 1'b1; cfg_period = 32'd5;
    tick();
    cfg_start = 1'b0;
    check("ign_err", {31'd0, cfg_err}, 32'd0);
    check_idle_bus("ign_bus");
    check("ign_run", {30'd0, running, busy}, 32'd2);

    // irq and snap_req together: ACK first, then the snapshot sequence
    tmr_irq = 1'b1; snap_req = 1'b1;
    tick();
    tmr_irq = 1'b0; snap_req = 1'b0;
    check_bus("ss_ack", 1'b1, 1'b0, 3'd0, 16'h0000);
    tick();
    check("ss_stb", {31'd0, sample_stb}, 32'd1);
    check("ss_count", {16'd0, sample_count}, 32'd3);
    tick();
    check_bus("ss_wr4", 1'b1, 1'b0, 3'd4, 16'h0000);
    tick();
    check_bus("ss_rd4", 1'b1, 1'b1, 3'd4, 16'h0000);
    tick();
    check_bus("ss_rd5", 1'b1, 1'b1, 3'd5, 16'h0000);
    tick();
    check_idle_bus("ss_cap_bus");
    check("ss_cap_busy", {31'd0, busy}, 32'd1);
    check("ss_cap_valid", {31'd0, snap_valid}, 32'd0);
    tick();
    check("ss_valid", {31'd0, snap_valid}, 32'd1);
    check("ss_value", snap_value, 32'h0001_2345);
    check("ss_run", {30'd0, running, busy}, 32'd2);
    tick();
    check("ss_valid_off", {31'd0, snap_valid}, 32'd0);

    // cfg_stop during SNAP_RL: snapshot completes, then the stop writes
    snap_lo = 16'hBEEF; snap_hi = 16'hCAFE;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check_bus("sp_wr4", 1'b1, 1'b0, 3'd4, 16'h0000);
    tick();
    check_bus("sp_rd4", 1'b1, 1'b1, 3'd4, 16'h0000);
    cfg_stop = 1'b1;
    tick();
    cfg_stop = 1'b0;
    check_bus("sp_rd5", 1'b1, 1'b1, 3'd5, 16'h0000);
    tick();
    check_idle_bus("sp_cap");
    tick();
    check("sp_valid", {31'd0, snap_valid}, 32'd1);
    check("sp_value", snap_value, 32'hCAFE_BEEF);
    check_idle_bus("sp_run_bus");
    tick();
    check_bus("sp_stop_ctl", 1'b1, 1'b0, 3'd1, 16'h0008);
    tick();
    check_bus("sp_stop_st", 1'b1, 1'b0, 3'd0, 16'h0000);
    check("sp_run_still", {31'd0, running}, 32'd1);
    tick();
    check("sp_idle", {30'd0, running, busy}, 32'd0);
    check_idle_bus("sp_idle_bus");
    tmr_irq = 1'b1;
    tick();
    check_idle_bus("sp_irq_idle1");
    tick();
    check_idle_bus("sp_irq_idle2");
    tmr_irq = 1'b0;

    // ticks 3: nine irqs give strobes on the 3rd, 6th and 9th
    stb_seen = 0;
    do_start("t3", 32'd1000, 8'd3);
    for (int i = 0; i < 9; i++) do_irq("t3_irq", (i % 3) == 2);
    check("t3_pulses", stb_seen, 32'd3);
    check("t3_count", {16'd0, sample_count}, 32'd3);
    do_stop("t3_stop");

    // ticks 0 behaves as 1; period exactly PERIOD_MIN is accepted
    stb_seen = 0;
    do_start("t0", 32'd8, 8'd0);
    for (int i = 0; i < 9; i++) do_irq("t0_irq", 1'b1);
    check("t0_pulses", stb_seen, 32'd9);
    check("t0_count", {16'd0, sample_count}, 32'd9);
    do_stop("t0_stop");

    // Reset in WR_PH, then a fresh start replays the whole write sequence
    cfg_start = 1'b1; cfg_period = 32'h0002_0010; cfg_ticks = 8'd1;
    tick();
    cfg_start = 1'b0;
    check_bus("rr_pl", 1'b1, 1'b0, 3'd2, 16'h0010);
    tick();
    check_bus("rr_ph", 1'b1, 1'b0, 3'd3, 16'h0002);
    reset = 1'b1;
    tick();
    check_idle_bus("rr_bus");
    check("rr_flags", {27'd0, running, busy, sample_stb, snap_valid, cfg_err}, 32'd0);
    check("rr_count", {16'd0, sample_count}, 32'd0);
    check("rr_snap", snap_value, 32'd0);
    reset = 1'b0;
    tick();
    check_idle_bus("rr_bus2");
    do_start("rr", 32'h0002_0010, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
